// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: lamp bit positions,
// the legal lamp patterns and the lamp legality check.
package traffic_pkg;

  localparam int EW_RED = 5;
  localparam int EW_YEL = 4;
  localparam int EW_GRN = 3;
  localparam int NS_RED = 2;
  localparam int NS_YEL = 1;
  localparam int NS_GRN = 0;

  localparam logic [5:0] LAMP_NS_GRN = 6'b100001;
  localparam logic [5:0] LAMP_NS_YEL = 6'b100010;
  localparam logic [5:0] LAMP_ALL_RED = 6'b100100;
  localparam logic [5:0] LAMP_EW_GRN = 6'b001100;
  localparam logic [5:0] LAMP_EW_YEL = 6'b010100;

  // A yellow is only safe while the crossing road shows red.
  function automatic logic lamp_illegal(input logic [5:0] l);
    logic bad;
    bad = ($countones(l[EW_RED:EW_GRN]) != 1) ||
          ($countones(l[NS_RED:NS_GRN]) != 1) ||
          (l[EW_GRN] && l[NS_GRN]) ||
          (l[EW_YEL] && !l[NS_RED]) ||
          (l[NS_YEL] && !l[EW_RED]);
    return bad;
  endfunction

endpackage

// File: rtl/car_detector_if.sv
// Loop-sensor / lamp / request bundle between the controller side and the detector.
interface car_detector_if;
  logic       ns_loop;
  logic       ew_loop;
  logic [5:0] lights;
  logic       nscar;
  logic       ewcar;
  logic       ns_present;
  logic       ew_present;
  logic       lamp_fault;

  modport master (
    output ns_loop, ew_loop, lights,
    input  nscar, ewcar, ns_present, ew_present, lamp_fault
  );

  modport slave (
    input  ns_loop, ew_loop, lights,
    output nscar, ewcar, ns_present, ew_present, lamp_fault
  );
endinterface

// File: rtl/loop_debounce.sv
// One induction loop: two-flop synchronizer followed by a stable-count debounce.
module loop_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic raw,
    output logic present
);

    localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE);

    logic       s1, s2;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Counter tracks consecutive disagreeing samples; any agreement restarts it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt     <= 8'd0;
            present <= 1'b0;
        end else if (s2 == present) begin
            cnt <= 8'd0;
        end else if (cnt + 8'd1 == DEB_LIM) begin
            cnt     <= 8'd0;
            present <= ~present;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/car_detector.sv
// Vehicle-presence front end: debounced loops, per-road request latches
// cleared by that road's green, and a sticky illegal-lamp detector.
module car_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic           clk,
    input  logic           clr_n,
    car_detector_if.slave  bus
);

    logic ns_pres, ew_pres;
    logic nscar_q, ewcar_q, fault_q;

    loop_debounce #(.DEBOUNCE(DEBOUNCE)) u_ns (
        .clk     (clk),
        .clr_n   (clr_n),
        .raw     (bus.ns_loop),
        .present (ns_pres)
    );

    loop_debounce #(.DEBOUNCE(DEBOUNCE)) u_ew (
        .clk     (clk),
        .clr_n   (clr_n),
        .raw     (bus.ew_loop),
        .present (ew_pres)
    );

    // Green clears the latch and wins over a simultaneous set.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            nscar_q <= 1'b0;
            ewcar_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            nscar_q <= !bus.lights[NS_GRN] && (nscar_q || ns_pres);
            ewcar_q <= !bus.lights[EW_GRN] && (ewcar_q || ew_pres);
            fault_q <= fault_q || lamp_illegal(bus.lights);
        end
    end

    assign bus.nscar      = nscar_q;
    assign bus.ewcar      = ewcar_q;
    assign bus.ns_present = ns_pres;
    assign bus.ew_present = ew_pres;
    assign bus.lamp_fault = fault_q;

endmodule

// File: tb/tb_car_detector.sv
// Self-checking bench for car_detector: vector table, directed corner cases
// and randomized loops/lamps against a sample-history reference model.
module tb_car_detector;

  localparam int DEB  = 4;
  localparam int HMAX = 8192;

  logic clk, clr_n;
  car_detector_if bus ();

  car_detector #(.DEBOUNCE(DEB)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [5:0] legal [5] = '{6'b100001, 6'b100010, 6'b100100, 6'b001100, 6'b010100};
  bit   rawh [2][HMAX];
  int   n;
  bit   m_pres [2];
  bit   m_car [2];
  bit   m_fault;

  function automatic bit is_legal(input logic [5:0] l);
    for (int i = 0; i < 5; i++)
      if (l == legal[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Debounce input seen at edge m is the raw value sampled two edges earlier.
  function automatic bit sample_at(input int r, input int m);
    if (m < 3) return 1'b0;
    return rawh[r][m-2];
  endfunction

  task automatic model_reset();
    n = 0;
    for (int r = 0; r < 2; r++) begin
      m_pres[r] = 1'b0;
      m_car[r]  = 1'b0;
    end
    m_fault = 1'b0;
  endtask

  task automatic model_edge(input bit ns, input bit ew, input logic [5:0] l);
    bit grn [2];
    bit flip;
    grn[0] = l[0];
    grn[1] = l[3];
    n++;
    if (n >= HMAX) begin
      $display("FAIL model_history overflow");
      $fatal(1, "history");
    end
    rawh[0][n] = ns;
    rawh[1][n] = ew;
    for (int r = 0; r < 2; r++) begin
      m_car[r] = !grn[r] && (m_car[r] || m_pres[r]);
      // Level flips once the last DEB samples all disagree with it.
      flip = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (n - j < 1 || sample_at(r, n - j) == m_pres[r]) flip = 1'b0;
      if (flip) m_pres[r] = !m_pres[r];
    end
    if (!is_legal(l)) m_fault = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(bus.ns_loop, bus.ew_loop, bus.lights);
    #1;
    chk("nscar",      {7'd0, bus.nscar},      {7'd0, m_car[0]});
    chk("ewcar",      {7'd0, bus.ewcar},      {7'd0, m_car[1]});
    chk("ns_present", {7'd0, bus.ns_present}, {7'd0, m_pres[0]});
    chk("ew_present", {7'd0, bus.ew_present}, {7'd0, m_pres[1]});
    chk("lamp_fault", {7'd0, bus.lamp_fault}, {7'd0, m_fault});
  endtask

  // Reset lands mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 clr_n = 1'b0;
    #1;
    chk("rst_outs", {3'd0, bus.nscar, bus.ewcar, bus.ns_present, bus.ew_present, bus.lamp_fault}, 8'd0);
    model_reset();
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  typedef struct {
    logic       ns;
    logic       ew;
    logic [5:0] lights;
    logic       ewp;
    logic       ewcar;
    logic       nscar;
  } vec_t;

  vec_t tbl [8];
  bit   seen;

  initial begin
    clr_n       = 1'b1;
    bus.ns_loop = 1'b0;
    bus.ew_loop = 1'b0;
    bus.lights  = 6'b100100;
    model_reset();
    do_reset();

    // EW arrival under NS green: presence at edge 6, request at edge 7.
    for (int e = 0; e < 8; e++) begin
      tbl[e].ns     = 1'b0;
      tbl[e].ew     = 1'b1;
      tbl[e].lights = 6'b100001;
      tbl[e].ewp    = (e + 1 >= DEB + 2);
      tbl[e].ewcar  = (e + 1 >= DEB + 3);
      tbl[e].nscar  = 1'b0;
    end
    for (int e = 0; e < 8; e++) begin
      bus.ns_loop = tbl[e].ns;
      bus.ew_loop = tbl[e].ew;
      bus.lights  = tbl[e].lights;
      step();
      chk($sformatf("tbl_ewp_e%0d", e + 1),   {7'd0, bus.ew_present}, {7'd0, tbl[e].ewp});
      chk($sformatf("tbl_ewcar_e%0d", e + 1), {7'd0, bus.ewcar},      {7'd0, tbl[e].ewcar});
      chk($sformatf("tbl_nscar_e%0d", e + 1), {7'd0, bus.nscar},      {7'd0, tbl[e].nscar});
    end

    // 3-cycle NS glitch under EW green must vanish.
    bus.lights  = 6'b001100;
    bus.ew_loop = 1'b0;
    seen = 1'b0;
    bus.ns_loop = 1'b1;
    repeat (3) begin step(); seen |= bus.nscar | bus.ns_present; end
    bus.ns_loop = 1'b0;
    repeat (8) begin step(); seen |= bus.nscar | bus.ns_present; end
    chk("glitch3_blocked", {7'd0, seen}, 8'd0);

    // 4-cycle pulse passes and the request holds after the car leaves.
    bus.ns_loop = 1'b1;
    repeat (4) step();
    bus.ns_loop = 1'b0;
    repeat (10) step();
    chk("pulse4_nscar_held", {7'd0, bus.nscar},      8'd1);
    chk("pulse4_released",   {7'd0, bus.ns_present}, 8'd0);

    // NS green clears next edge; still-present car re-requests once green ends.
    bus.ns_loop = 1'b1;
    bus.lights  = 6'b100001;
    step();
    chk("green_clear", {7'd0, bus.nscar}, 8'd0);
    repeat (8) step();
    chk("green_blocks_set", {6'd0, bus.ns_present, bus.nscar}, 8'b10);
    bus.lights = 6'b100100;
    step();
    chk("rerequest", {7'd0, bus.nscar}, 8'd1);

    // Both requests set, NS release mid-debounce, then asynchronous reset.
    bus.ew_loop = 1'b1;
    repeat (8) step();
    chk("both_set", {6'd0, bus.nscar, bus.ewcar}, 8'b11);
    bus.ns_loop = 1'b0;
    repeat (2) step();
    bus.ns_loop = 1'b1;
    bus.ew_loop = 1'b0;
    do_reset();
    for (int e = 1; e <= DEB + 3; e++) begin
      step();
      if (e == DEB + 1) chk("post_rst_nsp_early", {7'd0, bus.ns_present}, 8'd0);
      if (e == DEB + 2) chk("post_rst_nsp",       {6'd0, bus.ns_present, bus.nscar}, 8'b10);
      if (e == DEB + 3) chk("post_rst_nscar",     {7'd0, bus.nscar}, 8'd1);
    end

    // Randomized loops and legal lamp patterns.
    do_reset();
    for (int s = 0; s < 150; s++) begin
      int len;
      bus.ns_loop = 1'($urandom_range(0, 1));
      bus.ew_loop = 1'($urandom_range(0, 1));
      bus.lights  = legal[$urandom_range(0, 4)];
      len = $urandom_range(1, 2 * DEB + 1);
      repeat (len) step();
    end

    // Lamp checker: both greens, stickiness, legal cycling, double-lit group.
    bus.ns_loop = 1'b0;
    bus.ew_loop = 1'b0;
    do_reset();
    bus.lights = 6'b001001;
    step();
    chk("fault_both_green", {7'd0, bus.lamp_fault}, 8'd1);
    for (int i = 0; i < 20; i++) begin
      bus.lights = legal[i % 5];
      step();
    end
    chk("fault_sticky", {7'd0, bus.lamp_fault}, 8'd1);

    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      bus.lights = 6'b100001; step();
      bus.lights = 6'b100010; step();
      bus.lights = 6'b100100; step();
      bus.lights = 6'b001100; step();
      bus.lights = 6'b010100; step();
      bus.lights = 6'b100100; step();
    end
    chk("legal_no_fault", {7'd0, bus.lamp_fault}, 8'd0);
    bus.lights = 6'b110100;
    step();
    chk("fault_ew_two_lamps", {7'd0, bus.lamp_fault}, 8'd1);

    do_reset();
    bus.lights = 6'b010010;
    step();
    chk("fault_yel_no_red", {7'd0, bus.lamp_fault}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
